caravel_sram_scan: RTL and testbench

- GPIO-driven scan-chain test controller in the Caravel user project area, exercising the OpenRAM test SRAM macros.
- Serially shifts in a 112-bit command word and launches one access on the selected macro when global_csb is strobed low.
- Captures read data and parallel-loads it back into the scan register.
- Shifts the result out serially on gpio_out.

---
 rtl/caravel_sram_scan_pkg.sv | 51 +++++
 rtl/caravel_sram_scan_if.sv | 37 +++
 rtl/caravel_sram_scan_scan_reg.sv | 35 +++
 rtl/caravel_sram_scan.sv | 96 +++++++++
 tb/tb_caravel_sram_scan.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/caravel_sram_scan_pkg.sv
// Shared widths, chain field positions and command layout for the SRAM scan controller.
// Field positions are MSB-first along the 112-bit chain; bit 111 leaves on gpio_out first.
package caravel_sram_scan_pkg;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int SEL_W   = 4;
    localparam int WMASK_W = DATA_W / 8;
    localparam int CHAIN_W = SEL_W + 2 * (ADDR_W + DATA_W + 6);

    // sel values at or above this address single-port macros (no port 1)
    localparam int SP_BASE = 8;

    localparam int SEL_MSB    = 111;
    localparam int SEL_LSB    = 108;
    localparam int ADDR0_MSB  = 107;
    localparam int ADDR0_LSB  = 92;
    localparam int DIN0_MSB   = 91;
    localparam int DIN0_LSB   = 60;
    localparam int CSB0_BIT   = 59;
    localparam int WEB0_BIT   = 58;
    localparam int WMASK0_MSB = 57;
    localparam int WMASK0_LSB = 54;
    localparam int ADDR1_MSB  = 53;
    localparam int ADDR1_LSB  = 38;
    localparam int DIN1_MSB   = 37;
    localparam int DIN1_LSB   = 6;
    localparam int CSB1_BIT   = 5;
    localparam int WEB1_BIT   = 4;
    localparam int WMASK1_MSB = 3;
    localparam int WMASK1_LSB = 0;

    typedef struct packed {
        logic [SEL_W-1:0]   sel;
        logic [ADDR_W-1:0]  addr0;
        logic [DATA_W-1:0]  din0;
        logic               csb0;
        logic               web0;
        logic [WMASK_W-1:0] wmask0;
        logic [ADDR_W-1:0]  addr1;
        logic [DATA_W-1:0]  din1;
        logic               csb1;
        logic               web1;
        logic [WMASK_W-1:0] wmask1;
    } cmd_t;

    function automatic logic is_single_port(input logic [SEL_W-1:0] sel);
        return int'(sel) >= SP_BASE;
    endfunction

endpackage

// File: rtl/caravel_sram_scan_if.sv
// Bus between the scan controller and the externally muxed OpenRAM test macros.
interface caravel_sram_scan_if
    import caravel_sram_scan_pkg::*;
    ();

    // Access semantics: a port is accessed on every rising edge where its csb
    // is low; controls are sampled on that edge and dout is valid after it.
    // There is no ready back-pressure: the macro always accepts the access.
    logic [SEL_W-1:0]   sram_sel;
    logic               sram_csb0;
    logic               sram_web0;
    logic [WMASK_W-1:0] sram_wmask0;
    logic [ADDR_W-1:0]  sram_addr0;
    logic [DATA_W-1:0]  sram_din0;
    logic [DATA_W-1:0]  sram_dout0;
    logic               sram_csb1;
    logic               sram_web1;
    logic [WMASK_W-1:0] sram_wmask1;
    logic [ADDR_W-1:0]  sram_addr1;
    logic [DATA_W-1:0]  sram_din1;
    logic [DATA_W-1:0]  sram_dout1;

    modport master (
        output sram_sel,
        output sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0,
        output sram_csb1, sram_web1, sram_wmask1, sram_addr1, sram_din1,
        input  sram_dout0, sram_dout1
    );

    modport slave (
        input  sram_sel,
        input  sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0,
        input  sram_csb1, sram_web1, sram_wmask1, sram_addr1, sram_din1,
        output sram_dout0, sram_dout1
    );

endinterface

// File: rtl/caravel_sram_scan_scan_reg.sv
// 112-bit command/result scan register: serial shift, read-data parallel load,
// and an optional whole-chain load used by the logic-analyzer path.
module scan_reg
    import caravel_sram_scan_pkg::*;
    (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               scan,
    input  logic               load,
    input  logic               scan_bit,
    input  logic [DATA_W-1:0]  load_din0,
    input  logic [DATA_W-1:0]  load_din1,
    input  logic               alt_load,
    input  logic [CHAIN_W-1:0] alt_data,
    output logic [CHAIN_W-1:0] chain,
    output logic               scan_msb
);

    // Priority: reset > whole-chain load > read-data load > shift > hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= '0;
        end else if (alt_load) begin
            chain <= alt_data;
        end else if (load) begin
            chain[DIN0_MSB:DIN0_LSB] <= load_din0;
            chain[DIN1_MSB:DIN1_LSB] <= load_din1;
        end else if (scan) begin
            chain <= {chain[CHAIN_W-2:0], scan_bit};
        end
    end

    assign scan_msb = chain[CHAIN_W-1];

endmodule

// File: rtl/caravel_sram_scan.sv
// GPIO scan-chain test controller for the OpenRAM test macros: scan in a command,
// strobe global_csb, capture/load read data, scan the result out. Optional LA_EN adds LA chain access.
module caravel_sram_scan
    import caravel_sram_scan_pkg::*;
    (
    input  logic                gpio_clk,
    input  logic                gpio_resetn,
    input  logic                gpio_in,
    input  logic                gpio_scan,
    input  logic                gpio_sram_load,
    input  logic                global_csb,
    output logic                gpio_out,
    caravel_sram_scan_if.master sram
`ifdef LA_EN
    ,
    input  logic                la_mode,
    input  logic [CHAIN_W-1:0]  la_data_in,
    input  logic                la_load,
    output logic [CHAIN_W-1:0]  la_data_out
`endif
);

    logic [CHAIN_W-1:0] chain;
    cmd_t               cmd;
    logic               eff_csb0;
    logic               eff_csb1;
    logic               acc_q;
    logic               rd0_q;
    logic               rd1_q;
    logic [DATA_W-1:0]  dout0_q;
    logic [DATA_W-1:0]  dout1_q;
    logic               alt_load;
    logic [CHAIN_W-1:0] alt_data;

`ifdef LA_EN
    assign alt_load    = la_mode & la_load;
    assign alt_data    = la_data_in;
    assign la_data_out = chain;
`else
    assign alt_load = 1'b0;
    assign alt_data = '0;
`endif

    scan_reg u_scan_reg (
        .clk       (gpio_clk),
        .rst_n     (gpio_resetn),
        .scan      (gpio_scan),
        .load      (gpio_sram_load),
        .scan_bit  (gpio_in),
        .load_din0 (dout0_q),
        .load_din1 (dout1_q),
        .alt_load  (alt_load),
        .alt_data  (alt_data),
        .chain     (chain),
        .scan_msb  (gpio_out)
    );

    assign cmd = cmd_t'(chain);

    // The chain resets to all-zero (csb fields enabled), so reset itself must hold csb high
    assign eff_csb0 = global_csb | cmd.csb0 | ~gpio_resetn;
    assign eff_csb1 = global_csb | cmd.csb1 | ~gpio_resetn | is_single_port(cmd.sel);

    assign sram.sram_sel    = cmd.sel;
    assign sram.sram_csb0   = eff_csb0;
    assign sram.sram_web0   = cmd.web0;
    assign sram.sram_wmask0 = cmd.wmask0;
    assign sram.sram_addr0  = cmd.addr0;
    assign sram.sram_din0   = cmd.din0;
    assign sram.sram_csb1   = eff_csb1;
    assign sram.sram_web1   = cmd.web1;
    assign sram.sram_wmask1 = cmd.wmask1;
    assign sram.sram_addr1  = cmd.addr1;
    assign sram.sram_din1   = cmd.din1;

    // rdN_q remembers whether port N performed a read on the strobe edge; the
    // capture edge then takes macro data for reads and zero for writes/idle ports.
    always_ff @(posedge gpio_clk) begin
        if (!gpio_resetn) begin
            acc_q   <= 1'b0;
            rd0_q   <= 1'b0;
            rd1_q   <= 1'b0;
            dout0_q <= '0;
            dout1_q <= '0;
        end else begin
            acc_q <= ~global_csb;
            rd0_q <= ~eff_csb0 & cmd.web0;
            rd1_q <= ~eff_csb1 & cmd.web1;
            if (acc_q) begin
                dout0_q <= rd0_q ? sram.sram_dout0 : '0;
                dout1_q <= rd1_q ? sram.sram_dout1 : '0;
            end
        end
    end

endmodule

// File: tb/tb_caravel_sram_scan.sv
// Bench for caravel_sram_scan: directed vector table, hand sequences and a random
// command stream checked against a field-level access model. LA_EN enables the LA checks.
module tb_caravel_sram_scan;

    localparam int CW = 112;

    logic clk = 1'b0;
    logic gpio_resetn;
    logic gpio_in;
    logic gpio_scan;
    logic gpio_sram_load;
    logic global_csb;
    logic gpio_out;
`ifdef LA_EN
    logic          la_mode;
    logic [CW-1:0] la_data_in;
    logic          la_load;
    logic [CW-1:0] la_data_out;
`endif

    caravel_sram_scan_if sram_bus ();

    caravel_sram_scan dut (
        .gpio_clk       (clk),
        .gpio_resetn    (gpio_resetn),
        .gpio_in        (gpio_in),
        .gpio_scan      (gpio_scan),
        .gpio_sram_load (gpio_sram_load),
        .global_csb     (global_csb),
        .gpio_out       (gpio_out),
        .sram           (sram_bus.master)
`ifdef LA_EN
        ,
        .la_mode        (la_mode),
        .la_data_in     (la_data_in),
        .la_load        (la_load),
        .la_data_out    (la_data_out)
`endif
    );

    // ---------------- clock / reset ----------------
    initial forever #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- macro memories ----------------
    logic [31:0] sram_mem [int];
    logic [31:0] ref_mem [int];
    logic [CW-1:0] exp_q [$];
    int n_checks = 0;
    int n_fail = 0;
    int csb0_low = 0;
    int csb1_low = 0;

    function automatic int key(input logic [3:0] sel, input logic [15:0] addr);
        return int'({sel, addr});
    endfunction

    function automatic logic [31:0] init_val(input int k);
        return (32'(k) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] mask);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (mask[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] sram_rd(input int k);
        return sram_mem.exists(k) ? sram_mem[k] : init_val(k);
    endfunction

    function automatic logic [31:0] ref_rd(input int k);
        return ref_mem.exists(k) ? ref_mem[k] : init_val(k);
    endfunction

    // Behavioural macro pair: reads and writes act on the pins seen at the edge
    always @(posedge clk) begin : sram_model
        int k0;
        int k1;
        k0 = key(sram_bus.sram_sel, sram_bus.sram_addr0);
        k1 = key(sram_bus.sram_sel, sram_bus.sram_addr1);
        if (!gpio_resetn) begin
            sram_bus.sram_dout0 <= '0;
            sram_bus.sram_dout1 <= '0;
        end else begin
            if (!sram_bus.sram_csb0 && sram_bus.sram_web0) sram_bus.sram_dout0 <= sram_rd(k0);
            if (!sram_bus.sram_csb1 && sram_bus.sram_web1) sram_bus.sram_dout1 <= sram_rd(k1);
            if (!sram_bus.sram_csb0 && !sram_bus.sram_web0)
                sram_mem[k0] = merge(sram_rd(k0), sram_bus.sram_din0, sram_bus.sram_wmask0);
            if (!sram_bus.sram_csb1 && !sram_bus.sram_web1)
                sram_mem[k1] = merge(sram_rd(k1), sram_bus.sram_din1, sram_bus.sram_wmask1);
        end
    end

    always @(negedge clk) begin
        if (!sram_bus.sram_csb0) csb0_low++;
        if (!sram_bus.sram_csb1) csb1_low++;
    end

    // ---------------- reference model ----------------
    function automatic logic [CW-1:0] mk_cmd(
        input logic [3:0] sel, input logic [15:0] a0, input logic [31:0] d0,
        input logic c0, input logic w0, input logic [3:0] m0,
        input logic [15:0] a1, input logic [31:0] d1,
        input logic c1, input logic w1, input logic [3:0] m1);
        return {sel, a0, d0, c0, w0, m0, a1, d1, c1, w1, m1};
    endfunction

    // One complete access: the scanned-out result is the command with each din
    // field replaced by that port's read data, or zero if it wrote or was idle.
    function automatic logic [CW-1:0] model_access(input logic [CW-1:0] w);
        logic [3:0]  sel;
        logic [15:0] a0, a1;
        logic [31:0] d0, d1, r0, r1;
        logic        en0, en1;
        logic [CW-1:0] res;
        sel = w[111:108];
        a0  = w[107:92];
        d0  = w[91:60];
        a1  = w[53:38];
        d1  = w[37:6];
        en0 = !w[59];
        en1 = !w[5] && (sel < 4'd8);
        r0  = (en0 && w[58]) ? ref_rd(key(sel, a0)) : 32'd0;
        r1  = (en1 && w[4])  ? ref_rd(key(sel, a1)) : 32'd0;
        if (en0 && !w[58]) ref_mem[key(sel, a0)] = merge(ref_rd(key(sel, a0)), d0, w[57:54]);
        if (en1 && !w[4])  ref_mem[key(sel, a1)] = merge(ref_rd(key(sel, a1)), d1, w[3:0]);
        res = w;
        res[91:60] = r0;
        res[37:6]  = r1;
        return res;
    endfunction

    // ---------------- drivers / checks ----------------
    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic shift_word(input logic [CW-1:0] in_w, output logic [CW-1:0] out_w);
        out_w = '0;
        gpio_scan = 1'b1;
        for (int i = CW - 1; i >= 0; i--) begin
            out_w = {out_w[CW-2:0], gpio_out};
            gpio_in = in_w[i];
            tick();
        end
        gpio_scan = 1'b0;
        gpio_in = 1'b0;
    endtask

    // strobe -> capture -> load; optionally also raise gpio_scan on the load edge
    task automatic access_load(input logic with_scan);
        global_csb = 1'b0;
        tick();
        global_csb = 1'b1;
        tick();
        gpio_sram_load = 1'b1;
        if (with_scan) begin
            gpio_scan = 1'b1;
            gpio_in = 1'b1;
        end
        tick();
        gpio_sram_load = 1'b0;
        gpio_scan = 1'b0;
        gpio_in = 1'b0;
    endtask

    typedef struct {
        string         name;
        logic [CW-1:0] cmd;
        logic          preload;
        logic [31:0]   pre0;
        logic [31:0]   pre1;
        logic          with_scan;
        logic [CW-1:0] exp_word;
        int            exp_csb0_low;
        int            exp_csb1_low;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [CW-1:0]  rb;
        logic [CW-1:0]  junk;
        logic [127:0]   wide;
        logic [CW-1:0]  pat;

        vecs[0] = '{"write", mk_cmd(4'd2, 16'd1, 32'd2, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'hF),
                    1'b0, 32'd0, 32'd0, 1'b0,
                    mk_cmd(4'd2, 16'd1, 32'd0, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'hF), 1, 0};
        vecs[1] = '{"dual_read", mk_cmd(4'd3, 16'd1, 32'd0, 1'b0, 1'b1, 4'hF, 16'd2, 32'd0, 1'b0, 1'b1, 4'hF),
                    1'b1, 32'h3, 32'h18, 1'b1,
                    mk_cmd(4'd3, 16'd1, 32'h3, 1'b0, 1'b1, 4'hF, 16'd2, 32'h18, 1'b0, 1'b1, 4'hF), 1, 1};
        vecs[2] = '{"sp_read", mk_cmd(4'd9, 16'd4, 32'd0, 1'b0, 1'b1, 4'hF, 16'd6, 32'h5555, 1'b0, 1'b1, 4'hF),
                    1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0,
                    mk_cmd(4'd9, 16'd4, 32'hDEADBEEF, 1'b0, 1'b1, 4'hF, 16'd6, 32'd0, 1'b0, 1'b1, 4'hF), 1, 0};
        vecs[3] = '{"readback", mk_cmd(4'd2, 16'd1, 32'd0, 1'b0, 1'b1, 4'hF, 16'd5, 32'd0, 1'b0, 1'b1, 4'hF),
                    1'b0, 32'd0, 32'd0, 1'b0,
                    mk_cmd(4'd2, 16'd1, 32'd2, 1'b0, 1'b1, 4'hF, 16'd5, init_val(key(4'd2, 16'd5)),
                           1'b0, 1'b1, 4'hF), 1, 1};
        vecs[4] = '{"idle", mk_cmd(4'd5, 16'd3, 32'hAAAA, 1'b1, 1'b1, 4'hF, 16'd3, 32'hBBBB, 1'b1, 1'b1, 4'hF),
                    1'b0, 32'd0, 32'd0, 1'b0,
                    mk_cmd(4'd5, 16'd3, 32'd0, 1'b1, 1'b1, 4'hF, 16'd3, 32'd0, 1'b1, 1'b1, 4'hF), 0, 0};

        gpio_resetn = 1'b0;
        gpio_in = 1'b0;
        gpio_scan = 1'b0;
        gpio_sram_load = 1'b0;
        global_csb = 1'b0;
`ifdef LA_EN
        la_mode = 1'b0;
        la_load = 1'b0;
        la_data_in = '0;
`endif
        tick();
        tick();
        // global_csb is low here: only reset keeps the macros deselected
        check("reset_csb0_forced", 128'(sram_bus.sram_csb0), 128'd1);
        check("reset_csb1_forced", 128'(sram_bus.sram_csb1), 128'd1);
        global_csb = 1'b1;
        gpio_resetn = 1'b1;
        tick();
        check("reset_gpio_out", 128'(gpio_out), 128'd0);
        check("reset_csb0", 128'(sram_bus.sram_csb0), 128'd1);
        check("reset_csb1", 128'(sram_bus.sram_csb1), 128'd1);
        check("reset_dout0_q", 128'(dut.dout0_q), 128'd0);
        check("reset_dout1_q", 128'(dut.dout1_q), 128'd0);

        // reset mid-scan discards the partially shifted word
        gpio_scan = 1'b1;
        gpio_in = 1'b1;
        for (int i = 0; i < 60; i++) tick();
        gpio_resetn = 1'b0;
        tick();
        gpio_resetn = 1'b1;
        gpio_scan = 1'b0;
        gpio_in = 1'b0;
        shift_word('0, rb);
        check("midscan_reset", 128'(rb), 128'd0);

`ifdef LA_EN
        wide = {$urandom, $urandom, $urandom, $urandom};
        pat = wide[CW-1:0];
        la_mode = 1'b1;
        la_load = 1'b1;
        la_data_in = pat;
        tick();
        la_load = 1'b0;
        check("la_data_out", 128'(la_data_out), 128'(pat));
        check("la_gpio_out", 128'(gpio_out), 128'(pat[CW-1]));
        la_mode = 1'b0;
        la_load = 1'b1;
        la_data_in = ~pat;
        tick();
        la_load = 1'b0;
        check("la_ignored", 128'(la_data_out), 128'(pat));
`else
        wide = '0;
        pat = wide[CW-1:0];
`endif

        // directed vector table
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].preload) begin
                sram_mem[key(vecs[v].cmd[111:108], vecs[v].cmd[107:92])] = vecs[v].pre0;
                ref_mem[key(vecs[v].cmd[111:108], vecs[v].cmd[107:92])]  = vecs[v].pre0;
                sram_mem[key(vecs[v].cmd[111:108], vecs[v].cmd[53:38])]  = vecs[v].pre1;
                ref_mem[key(vecs[v].cmd[111:108], vecs[v].cmd[53:38])]   = vecs[v].pre1;
            end
            shift_word(vecs[v].cmd, junk);
            junk = model_access(vecs[v].cmd);
            csb0_low = 0;
            csb1_low = 0;
            access_load(vecs[v].with_scan);
            shift_word('0, rb);
            check({vecs[v].name, "_word"}, 128'(rb), 128'(vecs[v].exp_word));
            check({vecs[v].name, "_csb0_edges"}, 128'(csb0_low), 128'(vecs[v].exp_csb0_low));
            check({vecs[v].name, "_csb1_edges"}, 128'(csb1_low), 128'(vecs[v].exp_csb1_low));
            if (v == 0)
                check("write_landed", 128'(sram_rd(key(4'd2, 16'd1))), 128'd2);
        end

        // random command stream: each result is scanned out while the next command is scanned in
        for (int n = 0; n < 40; n++) begin
            logic [3:0]  sel;
            logic [15:0] a0, a1;
            logic [CW-1:0] c;
            sel = 4'($urandom_range(0, 15));
            a0 = 16'($urandom_range(0, 7));
            a1 = 16'($urandom_range(0, 7));
            if (a1 == a0) a1 = a0 ^ 16'd8;
            c = mk_cmd(sel, a0, $urandom, ($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom),
                       a1, $urandom, ($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom));
            shift_word(c, rb);
            if (exp_q.size() > 0) check($sformatf("rand_%0d", n - 1), 128'(rb), 128'(exp_q.pop_front()));
            exp_q.push_back(model_access(c));
            access_load(1'b0);
        end
        shift_word('0, rb);
        if (exp_q.size() > 0) check("rand_last", 128'(rb), 128'(exp_q.pop_front()));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
